// File: rtl/miriscv_pkg.sv
// Shared MiRiscV core definitions: datapath width, fetch bubble encoding and
// the instruction-bus adapter state type.
package miriscv_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- also used by the fetch unit as its bubble
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2,
        DRAIN       = 2'd3
    } ibus_state_e;

endpackage

// File: rtl/miriscv_instr_bus_adapter.sv
// Bridges the fetch unit's fixed-latency request port onto a req/gnt/rvalid
// instruction bus, one transaction in flight, with flush drop and response watchdog.
module miriscv_instr_bus_adapter
    import miriscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            core_req_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic            flush_i,
    output logic            core_rvalid_o,
    output logic [XLEN-1:0] core_rdata_o,
    output logic            core_err_o,
    output logic            core_stall_o,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    input  logic            mem_err_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic             WDOG_EN  = (TIMEOUT_CYCLES > 0);

    ibus_state_e     state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            drop_q, drop_d;
    logic            issue;
    logic            timeout_hit;

    // The counter is zero in the first WAIT_RVALID cycle, so the error fires
    // in the TIMEOUT_CYCLES-th cycle spent waiting.
    assign timeout_hit = WDOG_EN && (cnt_q == CNT_LAST);

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rdata_q <= NOP_INSTR;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rdata_d       = rdata_q;
        cnt_d         = cnt_q;
        drop_d        = drop_q;
        issue         = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = addr_q;
        core_rvalid_o = 1'b0;
        core_err_o    = 1'b0;
        core_rdata_o  = rdata_q;

        case (state_q)
            IDLE: begin
                issue = core_req_i && !flush_i;
            end
            WAIT_GNT: begin
                mem_req_o = 1'b1;
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                // A flush coinciding with the grant must also kill the response.
                if (mem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = (drop_q || flush_i) ? DRAIN : WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                    if (!flush_i) begin
                        core_rvalid_o = 1'b1;
                        core_rdata_o  = mem_rdata_i;
                        core_err_o    = mem_err_i;
                        rdata_d       = mem_rdata_i;
                        issue         = core_req_i;
                    end
                end else if (flush_i) begin
                    state_d = DRAIN;
                end else if (timeout_hit) begin
                    core_rvalid_o = 1'b1;
                    core_err_o    = 1'b1;
                    core_rdata_o  = NOP_INSTR;
                    rdata_d       = NOP_INSTR;
                    state_d       = DRAIN;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            mem_req_o  = 1'b1;
            mem_addr_o = core_addr_i;
            addr_d     = core_addr_i;
            drop_d     = 1'b0;
            cnt_d      = '0;
            state_d    = mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
    end

    assign core_stall_o = (state_q != IDLE) && !core_rvalid_o;

    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!arstn_i)
        (state_q == IDLE || state_q == WAIT_GNT) |-> !mem_rvalid_i);

    a_req_held: assert property (@(posedge clk_i) disable iff (!arstn_i)
        (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o)));

endmodule
